// File: rtl/shift_sub_div.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock.
// Define SHIFT_SUB_DIV_SIGNED_EN for two's-complement operands (adds one sign-correction clock).
module shift_sub_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StCorr, StDone} state_e;

  state_e           state_q, state_d;
  logic             start_q;
  logic [WIDTH-1:0] a_q, b_q, quo_q, rem_q;
  logic [WIDTH:0]   r_q;
  logic [CW-1:0]    cnt_q;
  logic             dbz_q;

  logic             accept, last, b_zero, qbit;
  logic [WIDTH+1:0] trial, diff;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] a_in, b_in;

  assign accept = start & ~start_q & ((state_q == StIdle) || (state_q == StDone));
  assign b_zero = (B == '0);
  assign last   = (cnt_q == CW'(1));

  // Top bit of diff is the borrow: no borrow means trial >= divisor.
  assign trial  = {r_q, a_q[WIDTH-1]};
  assign diff   = trial - {2'b00, b_q};
  assign qbit   = ~diff[WIDTH+1];
  assign r_next = qbit ? diff[WIDTH:0] : trial[WIDTH:0];

`ifdef SHIFT_SUB_DIV_SIGNED_EN
  logic qneg_q, rneg_q;

  assign a_in = A[WIDTH-1] ? -A : A;
  assign b_in = B[WIDTH-1] ? -B : B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      qneg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      rneg_q <= A[WIDTH-1];
    end
  end
`else
  assign a_in = A;
  assign b_in = B;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) state_d = b_zero ? StDone : StCalc;
      end
      StCalc: begin
`ifdef SHIFT_SUB_DIV_SIGNED_EN
        if (last) state_d = StCorr;
`else
        if (last) state_d = StDone;
`endif
      end
      StCorr:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StCalc, StCorr: busy = 1'b1;
      StDone:         done = 1'b1;
      default:        ;
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // Datapath; result registers move only at operation exit or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      start_q <= start;
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        r_q   <= '0;
        cnt_q <= CW'(WIDTH);
        dbz_q <= b_zero;
        if (b_zero) begin
          quo_q <= '1;
          rem_q <= A;
        end
      end else if (state_q == StCalc) begin
        a_q   <= {a_q[WIDTH-2:0], qbit};
        r_q   <= r_next;
        cnt_q <= cnt_q - CW'(1);
`ifndef SHIFT_SUB_DIV_SIGNED_EN
        if (last) begin
          quo_q <= {a_q[WIDTH-2:0], qbit};
          rem_q <= r_next[WIDTH-1:0];
        end
`endif
      end
`ifdef SHIFT_SUB_DIV_SIGNED_EN
      else if (state_q == StCorr) begin
        quo_q <= qneg_q ? -a_q : a_q;
        rem_q <= rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
      end
`endif
    end
  end

endmodule
